seg7_scan: RTL and testbench
============================

# seg7_scan

Multiplexed eight-digit seven-segment display driver for the board, downstream of the clock divider. It takes the divider's `clk_led` square wave as a data signal, synchronizes and edge-detects it in the `clk_board` domain, and advances one digit per `clk_led` rising edge. It shows a 32-bit hex value (CPU debug word) with per-digit decimal points and blanking. Inputs are captured once per frame so a digit never mixes old and new values.

## Interface
- `NDIGIT`, 8: number of digits scanned, legal 1..8; only the low `NDIGIT` bits/nibbles of each input are used.
- `clk_board`  in  1  board clock; the only clock in the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_led`  in  1  scan-rate square wave from the divider; treated as asynchronous data, never used as a clock.
- `value`  in  32  hex value; digit i shows `value[4i+3:4i]`.
- `dp`  in  8  decimal point request per digit, active-high.
- `blank`  in  8  force digit off, active-high.
- `an`  out  8  digit anodes, active-low, one-hot-low when a digit is lit; unused bits ≥ `NDIGIT` held 1.
- `seg`  out  7  segments {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a), active-low.
- `seg_dp`  out  1  decimal point segment, active-low.
- `frame`  out  1  one-cycle pulse on each frame reload (digit index wraps to 0).

## Operation
- Synchronizer: two flops `s1`, `s2` on `clk_led`, plus a history flop `s3 <= s2`. `tick = s2 & ~s3`.
- Digit index `idx`: 3 bits, range 0..NDIGIT-1. On `tick`: `idx <= (idx == NDIGIT-1) ? 0 : idx+1`.
- Frame reload: on a `tick` with `idx == NDIGIT-1`:
  - shadow registers `{value, dp, blank}` load from the live inputs;
  - `frame` = 1 for that one cycle;
  - digit 0's outputs are computed from the live inputs being loaded.
- Outputs are registered and updated only on `tick`:
  - `an` = all ones except bit `idx_next` = 0;
  - `seg` = ~decode(nibble);
  - `seg_dp` = ~dp_shadow[idx_next].
- If the digit is blanked: `an` = all ones, `seg` = 7'h7F, `seg_dp` = 1.
- Decode (active-high {g..a}):
  - digits 0–7: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - digits 8–F: 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Between ticks, outputs hold. Input changes between reloads have no visible effect.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - `s1`, `s2`, `s3` = 0; `idx` = NDIGIT-1; shadows = 0;
  - `an` = 8'hFF, `seg` = 7'h7F, `seg_dp` = 1, `frame` = 0.
- The display is dark until the first tick. Because `idx` resets to NDIGIT-1, the first tick is a frame reload and shows digit 0.
- Latency: `clk_led` first sampled high at `clk_board` edge k gives `s2` high after edge k+1, so `tick` is asserted in the cycle after edge k+1. Outputs, `idx`, shadows and `frame` update at edge k+2.
- One tick per `clk_led` rising edge, regardless of duty cycle. The high and low phases must each be ≥ 2 `clk_board` cycles; the divider guarantees 50 000.
- `clk_led` held constant produces no ticks, and the current digit stays lit.
- `NDIGIT` = 1: every tick is a reload; `an[0]` stays low after the first tick.
- Reset mid-frame: immediate dark display; restart at digit 0 on the next tick.
- `frame` is never asserted for two consecutive cycles.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression is applied at reload.
  - Digit i (i ≥ 1) is treated as blanked when shadow nibbles i..NDIGIT-1 are all zero.
  - Digit 0 is always shown unless `blank[0]` is set.
  - Suppression is ORed with `blank`.
- Undefined: only `blank` controls blanking; zeros display as "0".

## Test plan
- Reset, then 8 `clk_led` periods with `value` = 32'h89ABCDEF, `dp` = 0, `blank` = 0:
  - `an` steps FE, FD, FB, … 7F;
  - `seg` = ~71, ~79, ~5E, ~39, ~7C, ~77, ~6F, ~7F;
  - `frame` pulses once, on the first tick.
- Tearing: change `value` from 32'h00000000 to 32'h11111111 while digit 3 is lit. Digits 4–7 still show ~3F; the next frame shows ~06 on all digits.
- Latency: raise `clk_led` just before a `clk_board` edge. `an` changes exactly 2 edges later. A `clk_led` high pulse of 1 cycle is not guaranteed; 2 cycles gives exactly one tick.
- `dp` = 8'h04, `blank` = 8'h80:
  - digit 2 has `seg_dp` = 0;
  - at digit 7, `an` = 8'hFF and `seg` = 7'h7F.
- Assert `rst_n` low while digit 5 is lit: the same edge-independent response gives `an` = 8'hFF and `seg` = 7'h7F. After release, the first tick drives `an` = 8'hFE.
- With `SEG7_LZ_BLANK_EN` and `value` = 32'h00000A00:
  - digits 3–7 are dark;
  - digits 0–2 show ~3F, ~3F, ~77.
  - `value` = 0 shows only digit 0 as ~3F. Without the macro, all 8 digits are lit.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed seven-segment driver for the board.
//
// The divider's clk_led square wave is sampled as plain data in the
// clk_board domain. Each rising edge of clk_led advances the scan by one
// digit. The value, dp and blank inputs are captured once per frame, so a
// frame never mixes old and new data.
//
// Optional feature: define SEG7_LZ_BLANK_EN to enable leading-zero
// suppression. A digit i >= 1 goes dark when nibbles i..NDIGIT-1 of the
// captured value are all zero. Digit 0 always stays lit unless blank[0]
// is set.
`timescale 1ns/1ps

module seg7_scan #(
  parameter int NDIGIT = 8
) (
  input  logic        clk_board,
  input  logic        rst_n,
  input  logic        clk_led,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        frame
);

  // The scan index is three bits wide, so at most eight digits are possible.
  if (NDIGIT < 1 || NDIGIT > 8) begin : g_bad_ndigit
    $error("seg7_scan: NDIGIT must be in 1..8");
  end

  localparam logic [2:0] LAST_IDX = 3'(NDIGIT - 1);

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Synchronizer chain plus the history flop used for edge detection.
  logic s1_q, s2_q, s3_q;

  // Scan position and the per-frame captured inputs.
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [31:0] value_q;
  logic [7:0]  dp_q;
  logic [7:0]  blank_q;

  // Registered display outputs.
  logic [7:0] an_q;
  logic [6:0] seg_q;
  logic       seg_dp_q;
  logic       frame_q;

  // Per-cycle control and data for the digit about to be shown.
  logic        tick;
  logic        at_last;
  logic        reload;
  logic [31:0] src_value;
  logic [7:0]  src_dp;
  logic [7:0]  src_blank;
  logic [7:0]  lz_mask;
  logic [3:0]  nibble;
  logic        digit_dark;

  // Bring clk_led into the clk_board domain and keep one cycle of history.
  // NOTE: every clocked block uses <=; with = the chain s1->s2->s3 would
  // collapse into a single stage and the edge detector would never fire.
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_led;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Tick and reload decode, and selection of the data that feeds the next digit.
  // NOTE: each signal gets a value on every path through this block, either
  // directly or by a default first, so no latch is inferred.
  always_comb begin
    tick    = s2_q & ~s3_q;
    at_last = (idx_q == LAST_IDX);
    reload  = tick & at_last;
    idx_d   = at_last ? 3'd0 : idx_q + 3'd1;

    // On reload, digit 0 is built from the live inputs that are being
    // captured in the same cycle. Otherwise it comes from the frame copy.
    src_value = reload ? value : value_q;
    src_dp    = reload ? dp    : dp_q;
    src_blank = reload ? blank : blank_q;

    nibble = src_value[{idx_d, 2'b00} +: 4];
  end

  // Leading-zero mask: bit i is set when nibbles i..NDIGIT-1 are all zero.
  always_comb begin
    lz_mask = '0;
`ifdef SEG7_LZ_BLANK_EN
    begin : lz_scan
      logic zero_run;
      zero_run = 1'b1;
      for (int i = NDIGIT - 1; i >= 1; i--) begin
        zero_run   = zero_run & (src_value[4*i +: 4] == 4'h0);
        lz_mask[i] = zero_run;
      end
    end
`endif
    digit_dark = src_blank[idx_d] | lz_mask[idx_d];
  end

  // Advance the scan index on each tick and capture the inputs at frame wrap.
  // NOTE: the frame copies are reset along with the control state. A digit
  // shown before the first reload therefore reads as zero, not as X.
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= LAST_IDX;
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else begin
      if (tick) begin
        idx_q <= idx_d;
      end
      if (reload) begin
        value_q <= value;
        dp_q    <= dp;
        blank_q <= blank;
      end
    end
  end

  // Drive the anode, segments and decimal point for the new digit on each tick.
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      seg_dp_q <= 1'b1;
    end else if (tick) begin
      if (digit_dark) begin
        an_q     <= 8'hFF;
        seg_q    <= 7'h7F;
        seg_dp_q <= 1'b1;
      end else begin
        an_q     <= ~(8'h01 << idx_d);
        seg_q    <= ~seg7_decode(nibble);
        seg_dp_q <= ~src_dp[idx_d];
      end
    end
  end

  // One-cycle frame marker. Ticks are at least two cycles apart, so this
  // pulse never lasts two cycles in a row.
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= reload;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan. A behavioural model keeps a scan
// position counter and a per-frame copy of the inputs, and derives the
// expected outputs from the decode table. The leading-zero rule is applied
// arithmetically (value >> 4*pos == 0).
`timescale 1ns/1ps

module tb_seg7_scan;

  localparam int NDIGIT = 8;

  logic        clk_board = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clk_led   = 1'b0;
  logic [31:0] value     = '0;
  logic [7:0]  dp        = '0;
  logic [7:0]  blank     = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame;

  seg7_scan #(.NDIGIT(NDIGIT)) dut (
    .clk_board (clk_board),
    .rst_n     (rst_n),
    .clk_led   (clk_led),
    .value     (value),
    .dp        (dp),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .seg_dp    (seg_dp),
    .frame     (frame)
  );

  always #5 clk_board = ~clk_board;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  logic [6:0]  decode_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          pos;
  logic [31:0] snap_value;
  logic [7:0]  snap_dp, snap_blank;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_frame;

  function automatic void model_reset();
    pos       = NDIGIT - 1;
    exp_an    = 8'hFF;
    exp_seg   = 7'h7F;
    exp_dp    = 1'b1;
    exp_frame = 1'b0;
  endfunction

  // One scan step: move to the next digit, snapshot the inputs at frame start.
  function automatic void model_tick();
    logic dark;
    pos = (pos + 1) % NDIGIT;
    if (pos == 0) begin
      snap_value = value;
      snap_dp    = dp;
      snap_blank = blank;
    end
    dark = snap_blank[pos];
`ifdef SEG7_LZ_BLANK_EN
    if (pos >= 1 && (snap_value >> (4 * pos)) == 32'd0) dark = 1'b1;
`endif
    if (dark) begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_an  = ~(8'h01 << pos);
      exp_seg = ~decode_tab[snap_value[4*pos +: 4]];
      exp_dp  = ~snap_dp[pos];
    end
    exp_frame = (pos == 0);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".an"},     an,     exp_an);
    check({tag, ".seg"},    seg,    exp_seg);
    check({tag, ".seg_dp"}, seg_dp, exp_dp);
    check({tag, ".frame"},  frame,  exp_frame);
  endtask

  // One clk_led period: high for at least hi sampling edges, then low for lo.
  // Outputs must hold through the two synchronizer edges and change on the third.
  task automatic led_pulse(input int hi, input int lo);
    @(negedge clk_board);
    clk_led = 1'b1;
    @(negedge clk_board);                       // edge k sampled high
    check("lat_k.an", an, exp_an);
    @(negedge clk_board);                       // edge k+1
    check("lat_k1.an", an, exp_an);
    check("lat_k1.frame", frame, 1'b0);
    if (hi <= 2) clk_led = 1'b0;
    model_tick();
    @(negedge clk_board);                       // edge k+2: update visible
    check_outputs("tick");
    exp_frame = 1'b0;
    if (hi <= 3) clk_led = 1'b0;
    @(negedge clk_board);
    check("frame_width", frame, 1'b0);
    for (int c = 4; c < hi; c++) @(negedge clk_board);
    clk_led = 1'b0;
    for (int c = 0; c < lo; c++) @(negedge clk_board);
    check_outputs("hold");
  endtask

  task automatic sync_to_frame_end();
    while (pos != NDIGIT - 1) led_pulse(3, 3);
  endtask

  logic [7:0] walk_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] walk_pat [8] = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};

  initial begin
    logic [6:0] seg_req;
    logic [7:0] an_req;
    model_reset();

    // Reset state, during and after reset, before any tick.
    repeat (3) @(negedge clk_board);
    check_outputs("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_board);
    check_outputs("dark_before_tick");

    // Digit walk with explicit anode and segment expectations.
    value = 32'h89ABCDEF;
    dp    = 8'h00;
    blank = 8'h00;
    for (int i = 0; i < 8; i++) begin
      led_pulse(3, 3);
      seg_req = ~walk_pat[i];
      check("walk.an", an, walk_an[i]);
      check("walk.seg", seg, seg_req);
    end

    // Tearing: a value change mid-frame must wait for the next reload.
    value = 32'h0;
    for (int i = 0; i < 4; i++) led_pulse(3, 3);
    value   = 32'h11111111;
    seg_req = ~7'h3F;
    for (int i = 4; i < 8; i++) begin
      led_pulse(3, 3);
      check("tear_old.seg", seg, seg_req);
    end
    seg_req = ~7'h06;
    for (int i = 0; i < 8; i++) begin
      led_pulse(3, 3);
      check("tear_new.seg", seg, seg_req);
    end

    // Minimum two-cycle high phase gives exactly one tick per period.
    for (int i = 0; i < 4; i++) led_pulse(2, 2);

    // Decimal point on digit 2 and blanking of digit 7.
    value = 32'h89ABCDEF;
    dp    = 8'h04;
    blank = 8'h80;
    sync_to_frame_end();
    for (int i = 0; i < 8; i++) begin
      led_pulse(3, 3);
      if (i == 2) check("dp2.seg_dp", seg_dp, 1'b0);
      if (i == 7) begin
        check("blank7.an", an, 8'hFF);
        check("blank7.seg", seg, 7'h7F);
      end
    end

    // A constant clk_led leaves the current digit lit.
    dp    = 8'h00;
    blank = 8'h00;
    led_pulse(3, 3);
    for (int i = 0; i < 5; i++) begin
      repeat (4) @(negedge clk_board);
      check_outputs("no_edge_hold");
    end

    // Reset while digit 5 is lit: the display goes dark without a clock edge.
    while (pos != 5) led_pulse(3, 3);
    @(negedge clk_board);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.an", an, 8'hFF);
    check("async_rst.seg", seg, 7'h7F);
    check("async_rst.seg_dp", seg_dp, 1'b1);
    model_reset();
    repeat (2) @(negedge clk_board);
    rst_n = 1'b1;
    led_pulse(3, 3);
    check("restart.an", an, 8'hFE);

    // Leading-zero cases; the explicit expectation depends on the build option.
    value = 32'h00000A00;
    sync_to_frame_end();
    for (int i = 0; i < 8; i++) begin
      led_pulse(3, 3);
`ifdef SEG7_LZ_BLANK_EN
      an_req = (i >= 3) ? 8'hFF : walk_an[i];
`else
      an_req = walk_an[i];
`endif
      check("lz_a00.an", an, an_req);
      if (i == 2) check("lz_a00.seg2", seg, 7'(~7'h77));
    end
    value = 32'h0;
    for (int i = 0; i < 8; i++) begin
      led_pulse(3, 3);
`ifdef SEG7_LZ_BLANK_EN
      an_req = (i >= 1) ? 8'hFF : walk_an[i];
`else
      an_req = walk_an[i];
`endif
      check("lz_zero.an", an, an_req);
    end

    // Randomized traffic: inputs change at random points within a frame.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) value = $urandom;
      if ($urandom_range(0, 3) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 5) == 0) blank = 8'($urandom & $urandom & $urandom);
      led_pulse($urandom_range(2, 5), $urandom_range(2, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
